// File: rtl/bank_htu_pkg.sv
// Shared types for the line status tracker: per-offset coherence state and
// the clean/writeback sequencer state.
package bank_htu_pkg;

  typedef logic [1:0] off_state_t;

  localparam off_state_t EMPTY = 2'b00;
  localparam off_state_t SYNC  = 2'b01;
  localparam off_state_t DIRTY = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    WB   = 2'b10,
    DONE = 2'b11
  } clean_state_e;

  // The unused 2'b11 code reads back as EMPTY.
  function automatic off_state_t off_legal(input off_state_t s);
    return (s == 2'b11) ? EMPTY : s;
  endfunction

endpackage

// File: rtl/bank_htu_offset_cell.sv
// State flop and next-state rule for one offset of one tracked cacheline.
module bank_htu_offset_cell
  import bank_htu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       write_i,
  input  logic       hit_i,
  input  logic       line_hit_i,
  input  logic       alloc_i,
  input  logic       enable_i,
  input  logic       wb_clean_i,
  output off_state_t state_o
);

  off_state_t state_q, state_d, cur;

  always_comb begin
    cur     = off_legal(state_q);
    state_d = cur;
    if (wb_clean_i) begin
      state_d = SYNC;
    end else if (enable_i) begin
      if (alloc_i) begin
        if (!write_i)   state_d = SYNC;
        else if (hit_i) state_d = DIRTY;
        else            state_d = EMPTY;
      end else if (line_hit_i && hit_i) begin
        // A read hit only fills an empty slot; a write hit always dirties.
        if (write_i)            state_d = DIRTY;
        else if (cur == EMPTY)  state_d = SYNC;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= EMPTY;
    else         state_q <= state_d;
  end

  assign state_o = off_legal(state_q);

endmodule

// File: rtl/bank_htu_line_status.sv
// Per-offset status tracker for a bank of cachelines, with a clean sequencer
// that walks one line and issues a writeback for every DIRTY offset.
module bank_htu_line_status
  import bank_htu_pkg::*;
#(
  parameter  int NUM_LINES   = 4,
  parameter  int NUM_OFFSETS = 4,
  localparam int LINE_W      = $clog2(NUM_LINES),
  localparam int OFF_W       = $clog2(NUM_OFFSETS)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     upd_valid_i,
  output logic                     upd_ready_o,
  input  logic [LINE_W-1:0]        upd_line_i,
  input  logic                     upd_write_i,
  input  logic [NUM_OFFSETS-1:0]   upd_offset_mask_i,
  input  logic                     upd_line_hit_i,
  input  logic                     upd_line_alloc_i,
  input  logic                     clean_valid_i,
  output logic                     clean_ready_o,
  input  logic [LINE_W-1:0]        clean_line_i,
  output logic                     clean_done_o,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [LINE_W-1:0]        wb_line_o,
  output logic [OFF_W-1:0]         wb_offset_o,
  input  logic [LINE_W-1:0]        status_line_i,
  output logic [2*NUM_OFFSETS-1:0] status_o,
  output logic [NUM_LINES-1:0]     line_dirty_o
);

  clean_state_e        state_q, state_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [OFF_W-1:0]    cnt_q, cnt_d;
  off_state_t          st [NUM_LINES][NUM_OFFSETS];
  off_state_t          cur_off;
  logic                cnt_last, upd_acc, wb_hs;

  assign cnt_last = (cnt_q == OFF_W'(NUM_OFFSETS - 1));
  assign upd_acc  = upd_valid_i && upd_ready_o;
  assign wb_hs    = (state_q == WB) && wb_ready_i;
  assign cur_off  = st[line_q][cnt_q];

  for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
    for (genvar k = 0; k < NUM_OFFSETS; k++) begin : g_off
      bank_htu_offset_cell u_cell (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .write_i    (upd_write_i),
        .hit_i      (upd_offset_mask_i[k]),
        .line_hit_i (upd_line_hit_i),
        .alloc_i    (upd_line_alloc_i),
        .enable_i   (upd_acc && (upd_line_i == LINE_W'(l))),
        .wb_clean_i (wb_hs && (line_q == LINE_W'(l)) && (cnt_q == OFF_W'(k))),
        .state_o    (st[l][k])
      );
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      line_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (clean_valid_i) begin
        line_d  = clean_line_i;
        cnt_d   = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if (cur_off == DIRTY) state_d = WB;
        else if (cnt_last)    state_d = DONE;
        else                  cnt_d   = cnt_q + OFF_W'(1);
      end
      WB: if (wb_ready_i) begin
        if (cnt_last) begin
          state_d = DONE;
        end else begin
          state_d = SCAN;
          cnt_d   = cnt_q + OFF_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Updates to the line under clean are held off so the walk sees a stable line.
  always_comb begin
    clean_ready_o = (state_q == IDLE);
    wb_valid_o    = (state_q == WB);
    clean_done_o  = (state_q == DONE);
    wb_line_o     = line_q;
    wb_offset_o   = cnt_q;
    upd_ready_o   = (state_q == IDLE) || (upd_line_i != line_q);
  end

  always_comb begin
    status_o     = '0;
    line_dirty_o = '0;
    for (int k = 0; k < NUM_OFFSETS; k++) begin
      status_o[2*k +: 2] = st[status_line_i][k];
    end
    for (int l = 0; l < NUM_LINES; l++) begin
      for (int k = 0; k < NUM_OFFSETS; k++) begin
        if (st[l][k] == DIRTY) line_dirty_o[l] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bank_htu_line_status.sv
// Randomized and directed bench for bank_htu_line_status against a line/offset
// array model with a writeback queue.
module tb_bank_htu_line_status;

  localparam int NL = 4;
  localparam int NO = 4;
  localparam logic [1:0] M_EMPTY = 2'b00, M_SYNC = 2'b01, M_DIRTY = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       upd_valid = 1'b0, upd_write = 1'b0, upd_hit = 1'b0, upd_alloc = 1'b0;
  logic [1:0] upd_line = '0, clean_line = '0, status_line = '0;
  logic [3:0] upd_mask = '0;
  logic       clean_valid = 1'b0, wb_ready = 1'b0;

  logic       upd_ready_o, clean_ready_o, clean_done_o, wb_valid_o;
  logic [1:0] wb_line_o, wb_offset_o;
  logic [7:0] status_o;
  logic [3:0] line_dirty_o;

  always #5 clk = ~clk;

  bank_htu_line_status #(.NUM_LINES(NL), .NUM_OFFSETS(NO)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .upd_valid_i       (upd_valid),
    .upd_ready_o       (upd_ready_o),
    .upd_line_i        (upd_line),
    .upd_write_i       (upd_write),
    .upd_offset_mask_i (upd_mask),
    .upd_line_hit_i    (upd_hit),
    .upd_line_alloc_i  (upd_alloc),
    .clean_valid_i     (clean_valid),
    .clean_ready_o     (clean_ready_o),
    .clean_line_i      (clean_line),
    .clean_done_o      (clean_done_o),
    .wb_valid_o        (wb_valid_o),
    .wb_ready_i        (wb_ready),
    .wb_line_o         (wb_line_o),
    .wb_offset_o       (wb_offset_o),
    .status_line_i     (status_line),
    .status_o          (status_o),
    .line_dirty_o      (line_dirty_o)
  );

  // Reference model
  logic [1:0] m [NL][NO];
  int         q[$];
  logic       busy;
  int         cl_line, elapsed, waits, ndirty, hs_count, last_latency;
  int         n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_status(input int l);
    logic [7:0] v = '0;
    for (int k = 0; k < NO; k++) v[2*k +: 2] = m[l][k];
    return v;
  endfunction

  function automatic logic [3:0] m_dirty();
    logic [3:0] v = '0;
    for (int l = 0; l < NL; l++)
      for (int k = 0; k < NO; k++)
        if (m[l][k] == M_DIRTY) v[l] = 1'b1;
    return v;
  endfunction

  task automatic m_reset();
    for (int l = 0; l < NL; l++)
      for (int k = 0; k < NO; k++) m[l][k] = M_EMPTY;
    busy = 1'b0;
    q.delete();
    cl_line = 0;
  endtask

  task automatic m_update();
    for (int k = 0; k < NO; k++) begin
      if (upd_alloc) begin
        if (!upd_write)       m[upd_line][k] = M_SYNC;
        else if (upd_mask[k]) m[upd_line][k] = M_DIRTY;
        else                  m[upd_line][k] = M_EMPTY;
      end else if (upd_hit && upd_mask[k]) begin
        if (upd_write)                         m[upd_line][k] = M_DIRTY;
        else if (m[upd_line][k] == M_EMPTY)    m[upd_line][k] = M_SYNC;
      end
    end
  endtask

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic cycle();
    logic ua, ca, wh, dn, exp_urdy;
    @(negedge clk);
    if (busy) elapsed++;
    exp_urdy = !(busy && (int'(upd_line) == cl_line));
    chk("upd_ready", upd_ready_o, exp_urdy);
    chk("clean_ready", clean_ready_o, !busy);
    chk("status", status_o, m_status(status_line));
    chk("line_dirty", line_dirty_o, m_dirty());
    chk("wb_valid_without_pending", wb_valid_o && (q.size() == 0), 1'b0);
    chk("done_while_idle", clean_done_o && !busy, 1'b0);
    wh = 1'b0;
    dn = 1'b0;
    if (wb_valid_o && q.size() != 0) begin
      chk("wb_line", wb_line_o, cl_line);
      chk("wb_offset", wb_offset_o, q[0]);
      if (wb_ready) wh = 1'b1;
      else          waits++;
    end
    if (clean_done_o && busy) begin
      chk("done_queue_empty", q.size(), 0);
      chk("done_latency", elapsed, NO + 1 + ndirty + waits);
      last_latency = elapsed;
      dn = 1'b1;
    end else if (busy) begin
      chk("clean_timeout", elapsed > 300, 1'b0);
      if (elapsed > 300) dn = 1'b1;
    end
    ua = upd_valid && exp_urdy;
    ca = clean_valid && !busy;
    @(posedge clk);
    if (ua) m_update();
    if (wh) begin
      m[cl_line][q[0]] = M_SYNC;
      void'(q.pop_front());
      hs_count++;
    end
    if (dn) busy = 1'b0;
    if (ca) begin
      busy = 1'b1;
      cl_line = clean_line;
      elapsed = 0;
      waits = 0;
      q.delete();
      for (int k = 0; k < NO; k++) if (m[cl_line][k] == M_DIRTY) q.push_back(k);
      ndirty = q.size();
    end
    #1;
  endtask

  task automatic do_update(input int l, input logic wr, input logic [3:0] mask,
                           input logic hit, input logic alloc);
    upd_valid = 1'b1; upd_line = l[1:0]; upd_write = wr; upd_mask = mask;
    upd_hit = hit; upd_alloc = alloc;
    cycle();
    upd_valid = 1'b0;
  endtask

  task automatic start_clean(input int l);
    clean_valid = 1'b1; clean_line = l[1:0];
    cycle();
    clean_valid = 1'b0;
  endtask

  task automatic run_until_idle();
    for (int i = 0; i < 60 && busy; i++) cycle();
    chk("clean_finished", busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wb_valid"}, wb_valid_o, 1'b0);
    chk({tag, "_done"}, clean_done_o, 1'b0);
    chk({tag, "_clean_ready"}, clean_ready_o, 1'b1);
    chk({tag, "_line_dirty"}, line_dirty_o, 4'h0);
    for (int l = 0; l < NL; l++) begin
      status_line = l[1:0];
      #1;
      chk({tag, "_status"}, status_o, 8'h00);
    end
  endtask

  initial begin
    m_reset();
    hs_count = 0; last_latency = 0; elapsed = 0; waits = 0; ndirty = 0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Read-allocate line 2
    do_update(2, 1'b0, 4'h0, 1'b0, 1'b1);
    status_line = 2'd2; #1;
    chk("read_alloc_status", status_o, 8'h55);

    // Write-allocate line 1 with a partial mask
    do_update(1, 1'b1, 4'b0101, 1'b0, 1'b1);
    status_line = 2'd1; #1;
    chk("write_alloc_status", status_o, 8'h22);
    chk("write_alloc_dirty", line_dirty_o, 4'b0010);

    // Clean line 1 with writebacks always accepted
    wb_ready = 1'b1;
    hs_count = 0;
    start_clean(1);
    run_until_idle();
    status_line = 2'd1; #1;
    chk("clean1_wb_count", hs_count, 2);
    chk("clean1_status", status_o, 8'h11);
    chk("clean1_dirty", line_dirty_o, 4'h0);

    // Clean of an all-EMPTY line
    hs_count = 0;
    last_latency = 0;
    start_clean(3);
    run_until_idle();
    chk("clean3_wb_count", hs_count, 0);
    chk("clean3_latency", last_latency, NO + 1);

    // Writeback back-pressure
    do_update(0, 1'b1, 4'b0010, 1'b0, 1'b1);
    wb_ready = 1'b0;
    start_clean(0);
    for (int i = 0; i < 20 && !wb_valid_o; i++) cycle();
    chk("stall_wb_seen", wb_valid_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      upd_valid = 1'b1; upd_line = 2'd0; upd_write = 1'b1; upd_mask = 4'hf;
      upd_hit = 1'b1; upd_alloc = 1'b0;
      #1;
      chk("stall_same_line_blocked", upd_ready_o, 1'b0);
      chk("stall_wb_valid", wb_valid_o, 1'b1);
      chk("stall_wb_offset", wb_offset_o, 2'd1);
      cycle();
    end
    upd_line = 2'd2; upd_mask = 4'b1000; #1;
    chk("stall_other_line_ready", upd_ready_o, 1'b1);
    cycle();
    upd_valid = 1'b0;
    wb_ready = 1'b1;
    run_until_idle();

    // Reset while a writeback is pending
    do_update(1, 1'b1, 4'b1000, 1'b1, 1'b0);
    wb_ready = 1'b0;
    start_clean(1);
    for (int i = 0; i < 20 && !wb_valid_o; i++) cycle();
    chk("midwb_wb_seen", wb_valid_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midwb");
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      upd_valid   = ($urandom_range(0, 3) != 0);
      upd_line    = 2'($urandom_range(0, NL - 1));
      upd_write   = 1'($urandom_range(0, 1));
      upd_mask    = 4'($urandom_range(0, 15));
      upd_hit     = ($urandom_range(0, 3) != 0);
      upd_alloc   = ($urandom_range(0, 4) == 0);
      clean_valid = ($urandom_range(0, 7) == 0);
      clean_line  = 2'($urandom_range(0, NL - 1));
      wb_ready    = ($urandom_range(0, 9) < 6);
      status_line = 2'($urandom_range(0, NL - 1));
      cycle();
    end
    upd_valid = 1'b0;
    clean_valid = 1'b0;
    wb_ready = 1'b1;
    run_until_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
